// File: rtl/decode_branch_if.sv
// Fetch/execute-facing signal bundle for decode_branch. The decoder sits on the slave modport.
// DECODE_PERF_EN adds the perf_stall/perf_squash counter outputs.
interface decode_branch_if;
  logic [15:0] ins;
  logic        cell_zero;
  logic        ex_ready;
  logic        ex_retire;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [7:0]  ex_imm;
  logic        branch_en;
  logic [15:0] branch_val;
  logic        stall;
  logic [32:0] fork_cxt;
  logic        illegal;
`ifdef DECODE_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_squash;
`endif

  modport master (
    output ins, cell_zero, ex_ready, ex_retire,
    input  ex_valid, ex_op, ex_imm, branch_en, branch_val, stall, fork_cxt, illegal
`ifdef DECODE_PERF_EN
    , input perf_stall, perf_squash
`endif
  );

  modport slave (
    input  ins, cell_zero, ex_ready, ex_retire,
    output ex_valid, ex_op, ex_imm, branch_en, branch_val, stall, fork_cxt, illegal
`ifdef DECODE_PERF_EN
    , output perf_stall, perf_squash
`endif
  );
endinterface

// File: rtl/decode_branch.sv
// Decode stage: resolves JZ/JNZ/FORK locally, issues data ops through a 1-entry register.
// Define DECODE_PERF_EN to add saturating stall/squash counters.
module decode_branch #(
  parameter int unsigned PEND_W = 3
) (
  input logic           clk,
  input logic           rst_n,
  decode_branch_if.slave bus
);

  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpMov  = 4'h2;
  localparam logic [3:0] OpJz   = 4'h3;
  localparam logic [3:0] OpJnz  = 4'h4;
  localparam logic [3:0] OpOut  = 4'h5;
  localparam logic [3:0] OpIn   = 4'h6;
  localparam logic [3:0] OpFork = 4'h7;

  logic [3:0]        opcode;
  logic              is_jz, is_jnz, is_fork, is_data, is_cell_op, is_illegal;
  logic              active, pend_full, stall, take_branch, fork_valid, issue;
  logic              pend_inc, pend_dec;

  logic              squash_q, squash_d;
  logic              ex_valid_q, ex_valid_d;
  logic [3:0]        ex_op_q, ex_op_d;
  logic [7:0]        ex_imm_q, ex_imm_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [15:0]       thread_q, thread_d;
  logic              illegal_q, illegal_d;

  always_comb begin
    opcode     = bus.ins[15:12];
    is_jz      = (opcode == OpJz);
    is_jnz     = (opcode == OpJnz);
    is_fork    = (opcode == OpFork);
    is_cell_op = (opcode == OpAdd) || (opcode == OpMov) || (opcode == OpIn);
    is_data    = is_cell_op || (opcode == OpOut);
    is_illegal = opcode[3];
  end

  // A squashed slot is the one instruction fetch sent before it saw our redirect.
  assign active    = rst_n & ~squash_q;
  assign pend_full = &pending_q;

  always_comb begin
    stall = 1'b0;
    if (active) begin
      stall = ((is_jz || is_jnz) && (pending_q != '0)) ||
              (is_data && ex_valid_q && !bus.ex_ready) ||
              (is_cell_op && pend_full && !bus.ex_retire);
    end
  end

  assign take_branch = active & ~stall & ((is_jz & bus.cell_zero) | (is_jnz & ~bus.cell_zero));
  assign fork_valid  = active & is_fork;
  assign issue       = active & is_data & ~stall;

  assign pend_inc = issue & is_cell_op;
  assign pend_dec = bus.ex_retire & (pending_q != '0);

  always_comb begin
    squash_d   = take_branch | fork_valid;
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_imm_d   = ex_imm_q;
    pending_d  = pending_q;
    thread_d   = thread_q;
    illegal_d  = illegal_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_op_d    = opcode;
      ex_imm_d   = bus.ins[7:0];
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
    unique case ({pend_inc, pend_dec})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase
    if (fork_valid) thread_d = thread_q + 16'd1;
    if (active && is_illegal) illegal_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      squash_q   <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= 4'h0;
      ex_imm_q   <= 8'h00;
      pending_q  <= '0;
      thread_q   <= 16'h0000;
      illegal_q  <= 1'b0;
    end else begin
      squash_q   <= squash_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_imm_q   <= ex_imm_d;
      pending_q  <= pending_d;
      thread_q   <= thread_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_op      = ex_op_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.branch_en  = take_branch;
  assign bus.branch_val = {4'h0, bus.ins[11:0]};
  assign bus.stall      = stall;
  assign bus.fork_cxt   = {fork_valid, thread_q, 4'h0, bus.ins[11:0]};
  assign bus.illegal    = illegal_q;

`ifdef DECODE_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_squash_q, perf_squash_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_squash_d = perf_squash_q;
    if (stall && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    if (squash_q && (perf_squash_q != 16'hFFFF)) perf_squash_d = perf_squash_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q  <= 16'h0000;
      perf_squash_q <= 16'h0000;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_squash_q <= perf_squash_d;
    end
  end

  assign bus.perf_stall  = perf_stall_q;
  assign bus.perf_squash = perf_squash_q;
`endif

endmodule
